// File: rtl/writeback_arbiter_if.sv
// Writeback handshake bundle: ALU/LSU result offers in,
// register file write port and retire pulses out.
interface writeback_arbiter_if #(
  parameter int XLEN = 32
);
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_val;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_val;
  logic            w0en;
  logic [4:0]      w0addr;
  logic [XLEN-1:0] w0val;
  logic            retire_alu;
  logic            retire_lsu;
  logic [4:0]      retire_rd;

  modport master (
    output alu_valid, alu_rd, alu_val,
    output lsu_valid, lsu_rd, lsu_val,
    input  alu_ready, lsu_ready,
    input  w0en, w0addr, w0val,
    input  retire_alu, retire_lsu, retire_rd
  );

  modport slave (
    input  alu_valid, alu_rd, alu_val,
    input  lsu_valid, lsu_rd, lsu_val,
    output alu_ready, lsu_ready,
    output w0en, w0addr, w0val,
    output retire_alu, retire_lsu, retire_rd
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: one-entry ALU hold buffer, unbuffered LSU path,
// starvation-guarded arbitration, registered RF write + retire pulses.
// Ports: clk, rst (async active-low), flush, bus (slave modport).
module writeback_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 3
) (
  input logic                clk,
  input logic                rst,
  input logic                flush,
  writeback_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic            r_hold_v;
  logic [4:0]      r_hold_rd;
  logic [XLEN-1:0] r_hold_val;
  logic [CW-1:0]   r_cnt;

  logic            r_w0en;
  logic [4:0]      r_w0addr;
  logic [XLEN-1:0] r_w0val;
  logic            r_ret_alu;
  logic            r_ret_lsu;
  logic [4:0]      r_ret_rd;

  logic            w_starved;
  logic            w_grant_hold;
  logic            w_grant_lsu;
  logic            w_grant;
  logic            w_alu_load;
  logic [4:0]      w_sel_rd;
  logic [XLEN-1:0] w_sel_val;

  assign w_starved = (r_cnt == CW'(STARVE_LIMIT));

  // flush removes the hold entry from contention; LSU is unaffected
  always_comb begin
    w_grant_hold = 1'b0;
    w_grant_lsu  = 1'b0;
    if (r_hold_v && !flush &&
        (!bus.lsu_valid || w_starved))
      w_grant_hold = 1'b1;
    else if (bus.lsu_valid)
      w_grant_lsu = 1'b1;
  end

  assign w_grant   = w_grant_hold | w_grant_lsu;
  assign w_sel_rd  = w_grant_hold ? r_hold_rd : bus.lsu_rd;
  assign w_sel_val = w_grant_hold ? r_hold_val : bus.lsu_val;

  assign bus.alu_ready =
    !flush && (!r_hold_v || w_grant_hold);
  assign bus.lsu_ready = w_grant_lsu;

  assign w_alu_load = bus.alu_valid && bus.alu_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_v   <= 1'b0;
      r_hold_rd  <= '0;
      r_hold_val <= '0;
    end else if (flush) begin
      r_hold_v <= 1'b0;
    end else if (w_alu_load) begin
      r_hold_v   <= 1'b1;
      r_hold_rd  <= bus.alu_rd;
      r_hold_val <= bus.alu_val;
    end else if (w_grant_hold) begin
      r_hold_v <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_cnt <= '0;
    else if (flush || w_grant_hold || !r_hold_v)
      r_cnt <= '0;
    else if (w_grant_lsu && !w_starved)
      r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_w0en    <= 1'b0;
      r_w0addr  <= '0;
      r_w0val   <= '0;
      r_ret_alu <= 1'b0;
      r_ret_lsu <= 1'b0;
      r_ret_rd  <= '0;
    end else begin
      r_w0en    <= w_grant && (w_sel_rd != 5'd0);
      r_ret_alu <= w_grant_hold;
      r_ret_lsu <= w_grant_lsu;
      if (w_grant) begin
        r_w0addr <= w_sel_rd;
        r_w0val  <= w_sel_val;
        r_ret_rd <= w_sel_rd;
      end
    end
  end

  assign bus.w0en       = r_w0en;
  assign bus.w0addr     = r_w0addr;
  assign bus.w0val      = r_w0val;
  assign bus.retire_alu = r_ret_alu;
  assign bus.retire_lsu = r_ret_lsu;
  assign bus.retire_rd  = r_ret_rd;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Testbench for writeback_arbiter: per-cycle vector table
// plus hand sequences for async reset mid-operation.
module tb_writeback_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  writeback_arbiter_if #(.XLEN(32)) bus ();

  writeback_arbiter #(
    .XLEN(32),
    .STARVE_LIMIT(3)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] aval;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] lval;
    logic        fl;
    logic        ear;
    logic        elr;
    logic        ew;
    logic [4:0]  ea;
    logic [31:0] ev;
    logic        era;
    logic        erl;
    logic [4:0]  err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard,
    input logic [31:0] aval,
    input logic lv, input logic [4:0] lrd,
    input logic [31:0] lval, input logic fl,
    input logic ear, input logic elr,
    input logic ew, input logic [4:0] ea,
    input logic [31:0] ev,
    input logic era, input logic erl,
    input logic [4:0] err);
    vec_t v;
    v.av = av; v.ard = ard; v.aval = aval;
    v.lv = lv; v.lrd = lrd; v.lval = lval;
    v.fl = fl; v.ear = ear; v.elr = elr;
    v.ew = ew; v.ea = ea; v.ev = ev;
    v.era = era; v.erl = erl; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input logic av,
                       input logic [4:0] ard,
                       input logic [31:0] aval,
                       input logic lv,
                       input logic [4:0] lrd,
                       input logic [31:0] lval,
                       input logic fl);
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_val   = aval;
    bus.lsu_valid = lv;
    bus.lsu_rd    = lrd;
    bus.lsu_val   = lval;
    flush         = fl;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);

    // idle
    tbl.push_back(mk(0,0,0, 0,0,0, 0, 1,0,
                     0,0,0, 0,0,0));
    // single ALU rd5
    tbl.push_back(mk(1,5,32'hDEADBEEF, 0,0,0, 0, 1,0,
                     0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0, 1,0,
                     1,5,32'hDEADBEEF, 1,0,5));
    tbl.push_back(mk(0,0,0, 0,0,0, 0, 1,0,
                     0,5,32'hDEADBEEF, 0,0,0));
    // starvation: hold rd7 vs streaming LSU
    tbl.push_back(mk(1,7,32'h77, 0,0,0, 0, 1,0,
                     0,5,32'hDEADBEEF, 0,0,0));
    tbl.push_back(mk(0,0,0, 1,1,32'h101, 0, 0,1,
                     1,1,32'h101, 0,1,1));
    tbl.push_back(mk(0,0,0, 1,2,32'h102, 0, 0,1,
                     1,2,32'h102, 0,1,2));
    tbl.push_back(mk(0,0,0, 1,3,32'h103, 0, 0,1,
                     1,3,32'h103, 0,1,3));
    tbl.push_back(mk(0,0,0, 1,4,32'h104, 0, 1,0,
                     1,7,32'h77, 1,0,7));
    tbl.push_back(mk(0,0,0, 1,4,32'h104, 0, 1,1,
                     1,4,32'h104, 0,1,4));
    // LSU to x0: no write, retire fires
    tbl.push_back(mk(0,0,0, 1,0,32'h1234, 0, 1,1,
                     0,0,32'h1234, 0,1,0));
    // flush discards hold rd9
    tbl.push_back(mk(1,9,32'h99, 0,0,0, 0, 1,0,
                     0,0,32'h1234, 0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 1, 0,0,
                     0,0,32'h1234, 0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0, 1,0,
                     0,0,32'h1234, 0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0, 1,0,
                     0,0,32'h1234, 0,0,0));
    // flush leaves LSU path alone
    tbl.push_back(mk(1,10,32'hA, 0,0,0, 0, 1,0,
                     0,0,32'h1234, 0,0,0));
    tbl.push_back(mk(0,0,0, 1,11,32'hB, 1, 0,1,
                     1,11,32'hB, 0,1,11));
    tbl.push_back(mk(0,0,0, 0,0,0, 0, 1,0,
                     0,11,32'hB, 0,0,0));
    // write registered before a flush survives
    tbl.push_back(mk(1,12,32'hC, 0,0,0, 0, 1,0,
                     0,11,32'hB, 0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0, 1,0,
                     1,12,32'hC, 1,0,12));
    tbl.push_back(mk(0,0,0, 0,0,0, 1, 0,0,
                     0,12,32'hC, 0,0,0));
    // back-to-back ALU, 1 per cycle
    tbl.push_back(mk(1,20,32'h20, 0,0,0, 0, 1,0,
                     0,12,32'hC, 0,0,0));
    tbl.push_back(mk(1,21,32'h21, 0,0,0, 0, 1,0,
                     1,20,32'h20, 1,0,20));
    tbl.push_back(mk(1,22,32'h22, 0,0,0, 0, 1,0,
                     1,21,32'h21, 1,0,21));
    tbl.push_back(mk(1,23,32'h23, 0,0,0, 0, 1,0,
                     1,22,32'h22, 1,0,22));
    tbl.push_back(mk(0,0,0, 0,0,0, 0, 1,0,
                     1,23,32'h23, 1,0,23));
    tbl.push_back(mk(0,0,0, 0,0,0, 0, 1,0,
                     0,23,32'h23, 0,0,0));

    // reset state
    #2;
    chk("rst_w0en",   32'(bus.w0en), 0);
    chk("rst_w0addr", 32'(bus.w0addr), 0);
    chk("rst_w0val",  bus.w0val, 0);
    chk("rst_ret_alu", 32'(bus.retire_alu), 0);
    chk("rst_ret_lsu", 32'(bus.retire_lsu), 0);
    chk("rst_ret_rd", 32'(bus.retire_rd), 0);
    chk("rst_alu_ready", 32'(bus.alu_ready), 1);
    chk("rst_lsu_ready", 32'(bus.lsu_ready), 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].av, tbl[i].ard, tbl[i].aval,
            tbl[i].lv, tbl[i].lrd, tbl[i].lval,
            tbl[i].fl);
      #1;
      chk($sformatf("v%0d_alu_ready", i),
          32'(bus.alu_ready), 32'(tbl[i].ear));
      chk($sformatf("v%0d_lsu_ready", i),
          32'(bus.lsu_ready), 32'(tbl[i].elr));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_w0en", i),
          32'(bus.w0en), 32'(tbl[i].ew));
      chk($sformatf("v%0d_w0addr", i),
          32'(bus.w0addr), 32'(tbl[i].ea));
      chk($sformatf("v%0d_w0val", i),
          bus.w0val, tbl[i].ev);
      chk($sformatf("v%0d_ret_alu", i),
          32'(bus.retire_alu), 32'(tbl[i].era));
      chk($sformatf("v%0d_ret_lsu", i),
          32'(bus.retire_lsu), 32'(tbl[i].erl));
      if (tbl[i].era || tbl[i].erl)
        chk($sformatf("v%0d_ret_rd", i),
            32'(bus.retire_rd), 32'(tbl[i].err));
    end

    // async reset with a write pending and hold loaded
    @(negedge clk);
    drive(1, 14, 32'hE, 1, 3, 32'h33, 0);
    @(posedge clk);
    #1;
    chk("mr_w0en_pre", 32'(bus.w0en), 1);
    chk("mr_w0addr_pre", 32'(bus.w0addr), 3);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    rst = 1'b0;
    #1;
    chk("mr_w0en", 32'(bus.w0en), 0);
    chk("mr_w0addr", 32'(bus.w0addr), 0);
    chk("mr_w0val", bus.w0val, 0);
    chk("mr_ret_lsu", 32'(bus.retire_lsu), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_alu_ready", 32'(bus.alu_ready), 1);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("mr_post%0d_w0en", k),
          32'(bus.w0en), 0);
      chk($sformatf("mr_post%0d_ret_alu", k),
          32'(bus.retire_alu), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writeback stage directly upstream of the register file's single write port (w0en/w0addr/w0val).
- Merges results from the ALU and the load/store unit (LSU) through valid/ready handshakes.
- Buffers one ALU result and arbitrates with a starvation guard.
- Drives a registered write to the register file and emits retire pulses for scoreboard release.

Parameters:
- XLEN, 32, data width of results and register values.
- STARVE_LIMIT, 3, consecutive lost arbitrations after which the buffered ALU result wins (must be >= 1); counter width is clog2(STARVE_LIMIT+1).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- flush  input  1  synchronous; discards the buffered ALU entry.
- alu_valid  input  1  ALU result offered.
- alu_ready  output  1  ALU result accepted this cycle when alu_valid is also high.
- alu_rd  input  5  ALU destination register.
- alu_val  input  XLEN  ALU result.
- lsu_valid  input  1  load result offered.
- lsu_ready  output  1  load result accepted this cycle when lsu_valid is also high.
- lsu_rd  input  5  load destination register.
- lsu_val  input  XLEN  load data.
- w0en  output  1  register file write enable.
- w0addr  output  5  register file write address.
- w0val  output  XLEN  register file write data.
- retire_alu  output  1  one-cycle pulse: an ALU result left the arbiter.
- retire_lsu  output  1  one-cycle pulse: an LSU result left the arbiter.
- retire_rd  output  5  destination of the retiring result.

Behaviour:
- Reset (rst=0, async):
  - hold entry empty; starve_cnt=0.
  - w0en=0, w0addr=0, w0val=0.
  - retire_alu=0, retire_lsu=0, retire_rd=0.
- ALU hold register (hold_v, hold_rd, hold_val):
  - alu_ready = !hold_v || grant_hold (combinational).
  - On alu_valid && alu_ready, the hold register loads alu_rd/alu_val at the edge.
- LSU path is unbuffered: lsu_ready = grant_lsu (combinational).
- Arbitration (combinational, each cycle):
  - hold_v only: grant_hold.
  - lsu_valid only: grant_lsu.
  - both: grant_lsu unless starve_cnt == STARVE_LIMIT, then grant_hold.
  - At most one grant per cycle.
  - The register file never back-pressures, so any valid candidate is granted in its cycle.
- starve_cnt:
  - Resets to 0 when grant_hold or !hold_v.
  - Increments when hold_v && grant_lsu.
  - Saturates at STARVE_LIMIT.
- Output stage (registered; the edge after the grant):
  - w0en <= grant && (sel_rd != 0). x0 writes are suppressed.
  - w0addr/w0val <= selected rd/val on any grant; otherwise they hold their value.
  - retire_alu <= grant_hold; retire_lsu <= grant_lsu.
  - retire_rd <= sel_rd. Retire pulses fire even for rd==0.
- Latency:
  - LSU accepted in cycle N: w0en high in cycle N+1; the register file captures at the end of N+1; the value is readable in N+2.
  - ALU accepted in cycle N: earliest w0en is N+2.
- Simultaneous events:
  - alu_valid accepted in the same cycle that the hold entry is granted: the new entry replaces the old (back-to-back ALU throughput of 1 per cycle when LSU is idle).
  - flush has priority over loading and grant: the hold entry is cleared, no grant_hold that cycle, alu_ready=0 that cycle, starve_cnt=0.
  - flush does not cancel an output write already registered. The LSU path is unaffected by flush.
- Reset mid-operation: the hold entry is lost and any pending write is dropped; w0en=0 immediately (async).
- Ordering: results for the same rd arriving on both paths are the issuer's responsibility; no reordering occurs inside a source.

Test Plan:
- Reset then idle → w0en=0, retire_alu=0, retire_lsu=0, alu_ready=1, lsu_ready=0.
- Single ALU result alu_rd=5, alu_val=0xDEADBEEF in cycle 0 → w0en=1, w0addr=5, w0val=0xDEADBEEF in cycle 2; retire_alu pulse in cycle 2 only.
- ALU rd=7 buffered, lsu_valid held high with rd=1,2,3,4,… (STARVE_LIMIT=3) → LSU wins 3 cycles, then the hold entry wins (w0addr=7, retire_alu=1), and lsu_ready=0 in that grant cycle.
- LSU lsu_rd=0, lsu_val=0x1234 → w0en stays 0, retire_lsu=1, retire_rd=0.
- Hold entry valid (rd=9) with flush=1 and lsu idle → no write to 9 ever; alu_ready=0 in the flush cycle, then 1.
- Continuous alu_valid with 4 results, LSU idle → 4 consecutive w0en cycles, addresses in order, alu_ready never drops.
